// File: rtl/jpg_axis.sv
// AXI4-Stream JPEG front end: buffers one planar 8x8 RGB block, converts it to
// BT.601 full-range YCbCr and streams the Y, Cb and Cr planes one sample per beat.
module jpg_axis #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_START_COUNT = 32,
  parameter int DATA_WIDTH             = 32,
  parameter int INPUT_WIDTH            = 8,
  parameter int DATA_DEPTH             = 8,
  parameter int PIXEL_COUNT            = 64
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  input  logic                                  s00_axis_tvalid,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready
);
  localparam int PIX_PER_BEAT = C_S00_AXIS_TDATA_WIDTH / INPUT_WIDTH;
  localparam int BEATS        = PIXEL_COUNT / PIX_PER_BEAT;
  localparam int IDX_W        = $clog2(PIXEL_COUNT);
  localparam int BEAT_W       = $clog2(BEATS);
  localparam int ACC_W        = 27;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << INPUT_WIDTH) - 1);
  localparam logic signed [ACC_W-1:0] C_OFS   = ACC_W'(128 << 16);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(32768);

  // Handshake rule on both ports: a beat transfers on a rising edge where
  // tvalid and tready are both high; tvalid/tdata/tlast hold until then.
  typedef enum logic [2:0] {
    S_RECV_R, S_RECV_G, S_RECV_B, S_WAIT, S_SEND_Y, S_SEND_CB, S_SEND_CR
  } state_t;

  state_t                  state;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [IDX_W-1:0]        sample_cnt;
  logic [31:0]             delay_cnt;
  logic [INPUT_WIDTH-1:0]  r_buf [PIXEL_COUNT];
  logic [INPUT_WIDTH-1:0]  g_buf [PIXEL_COUNT];
  logic [INPUT_WIDTH-1:0]  b_buf [PIXEL_COUNT];

  logic                    in_hs, out_hs, beat_last, sample_last;
  logic [1:0]              ld_plane;
  logic [IDX_W-1:0]        ld_idx;
  logic signed [ACC_W-1:0] r_px, g_px, b_px, acc, shf;
  logic [INPUT_WIDTH-1:0]  sample;
  logic                    unused_in;

  assign in_hs          = s00_axis_tvalid & s00_axis_tready;
  assign out_hs         = m00_axis_tvalid & m00_axis_tready;
  assign beat_last      = (beat_cnt == BEAT_W'(BEATS - 1));
  assign sample_last    = (sample_cnt == IDX_W'(PIXEL_COUNT - 1));
  assign m00_axis_tstrb = '1;
  assign unused_in      = ^{m00_axis_aclk, m00_axis_aresetn, s00_axis_tstrb, s00_axis_tlast};

  // Pixel storage carries no reset; it is always fully rewritten before use.
  always_ff @(posedge s00_axis_aclk) begin
    if (in_hs) begin
      for (int k = 0; k < PIX_PER_BEAT; k++) begin
        case (state)
          S_RECV_R: r_buf[IDX_W'(int'(beat_cnt) * PIX_PER_BEAT + k)] <= s00_axis_tdata[k*INPUT_WIDTH +: INPUT_WIDTH];
          S_RECV_G: g_buf[IDX_W'(int'(beat_cnt) * PIX_PER_BEAT + k)] <= s00_axis_tdata[k*INPUT_WIDTH +: INPUT_WIDTH];
          S_RECV_B: b_buf[IDX_W'(int'(beat_cnt) * PIX_PER_BEAT + k)] <= s00_axis_tdata[k*INPUT_WIDTH +: INPUT_WIDTH];
          default: ;
        endcase
      end
    end
  end

  // Selects the sample that the next output register load will carry.
  always_comb begin
    ld_plane = 2'd0;
    ld_idx   = sample_cnt + IDX_W'(1);
    case (state)
      S_SEND_Y: if (sample_last) begin ld_plane = 2'd1; ld_idx = '0; end
      S_SEND_CB: begin
        ld_plane = 2'd1;
        if (sample_last) begin ld_plane = 2'd2; ld_idx = '0; end
      end
      S_SEND_CR: ld_plane = 2'd2;
      default: ld_idx = '0;
    endcase
  end

  always_comb begin
    r_px = $signed({{(ACC_W-INPUT_WIDTH){1'b0}}, r_buf[ld_idx]});
    g_px = $signed({{(ACC_W-INPUT_WIDTH){1'b0}}, g_buf[ld_idx]});
    b_px = $signed({{(ACC_W-INPUT_WIDTH){1'b0}}, b_buf[ld_idx]});
    case (ld_plane)
      2'd0:    acc = 27'sd19595 * r_px + 27'sd38470 * g_px + 27'sd7471 * b_px;
      2'd1:    acc = 27'sd32768 * b_px - 27'sd11059 * r_px - 27'sd21709 * g_px + C_OFS;
      default: acc = 27'sd32768 * r_px - 27'sd27439 * g_px - 27'sd5329 * b_px + C_OFS;
    endcase
    shf = (acc + RND) >>> 16;
    if (shf[ACC_W-1])     sample = '0;
    else if (shf > PIX_MAX) sample = '1;
    else                  sample = shf[INPUT_WIDTH-1:0];
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state           <= S_RECV_R;
      beat_cnt        <= '0;
      sample_cnt      <= '0;
      delay_cnt       <= '0;
      s00_axis_tready <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        S_RECV_R, S_RECV_G, S_RECV_B: begin
          s00_axis_tready <= 1'b1;
          if (in_hs) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_last) begin
              beat_cnt <= '0;
              if (state == S_RECV_R)      state <= S_RECV_G;
              else if (state == S_RECV_G) state <= S_RECV_B;
              else begin
                state           <= S_WAIT;
                s00_axis_tready <= 1'b0;
                delay_cnt       <= '0;
              end
            end
          end
        end
        S_WAIT: begin
          if (delay_cnt == 32'(C_M00_AXIS_START_COUNT - 1)) begin
            state           <= S_SEND_Y;
            sample_cnt      <= '0;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= {{(DATA_WIDTH-INPUT_WIDTH){1'b0}}, sample};
            m00_axis_tlast  <= (ld_idx == IDX_W'(PIXEL_COUNT - 1));
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end
        default: begin
          if (out_hs) begin
            if (sample_last && state == S_SEND_CR) begin
              state           <= S_RECV_R;
              sample_cnt      <= '0;
              m00_axis_tvalid <= 1'b0;
              m00_axis_tdata  <= '0;
              m00_axis_tlast  <= 1'b0;
              s00_axis_tready <= 1'b1;
            end else begin
              if (sample_last) state <= (state == S_SEND_Y) ? S_SEND_CB : S_SEND_CR;
              sample_cnt     <= ld_idx;
              m00_axis_tdata <= {{(DATA_WIDTH-INPUT_WIDTH){1'b0}}, sample};
              m00_axis_tlast <= (ld_idx == IDX_W'(PIXEL_COUNT - 1));
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jpg_axis.sv
// Bench for jpg_axis: directed blocks, a YCbCr reference model feeding an
// expected queue, and one negedge compare process checking every output beat.
module tb_jpg_axis;
  localparam int START = 32;

  logic        clk = 1'b0;
  logic        s00_axis_aresetn;
  logic        s00_axis_tready;
  logic [31:0] s00_axis_tdata;
  logic [3:0]  s00_axis_tstrb;
  logic        s00_axis_tlast;
  logic        s00_axis_tvalid;
  logic        m00_axis_tvalid;
  logic [31:0] m00_axis_tdata;
  logic [3:0]  m00_axis_tstrb;
  logic        m00_axis_tlast;
  logic        m00_axis_tready;

  jpg_axis dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(s00_axis_aresetn),
    .m00_axis_aclk(clk), .m00_axis_aresetn(s00_axis_aresetn),
    .s00_axis_tready(s00_axis_tready), .s00_axis_tdata(s00_axis_tdata),
    .s00_axis_tstrb(s00_axis_tstrb), .s00_axis_tlast(s00_axis_tlast),
    .s00_axis_tvalid(s00_axis_tvalid), .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tlast(m00_axis_tlast), .m00_axis_tready(m00_axis_tready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_in_cyc = 0;
  int          out_cnt  = 0;
  bit          blk_first = 0;
  bit          bp_mode  = 0;
  int          pix_r [64];
  int          pix_g [64];
  int          pix_b [64];
  int          got_buf [192];
  int          tlast_pos [$];
  logic [32:0] exp_q [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_px(input int plane, input int r, input int g, input int b);
    int v;
    case (plane)
      0:       v = 19595 * r + 38470 * g + 7471 * b;
      1:       v = -11059 * r - 21709 * g + 32768 * b + (128 << 16);
      default: v = 32768 * r - 27439 * g - 5329 * b + (128 << 16);
    endcase
    v = (v + 32768) >>> 16;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic build_expected();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 64; i++)
        exp_q.push_back({(i == 63), 32'(model_px(p, pix_r[i], pix_g[i], pix_b[i]))});
  endtask

  task automatic set_gradient();
    for (int i = 0; i < 64; i++) begin
      pix_r[i] = (i % 8) * 30 + 10;
      pix_g[i] = (i / 8) * 30 + 10;
      pix_b[i] = ((i % 8) + (i / 8)) * 15 + 10;
    end
  endtask

  task automatic set_saturate();
    for (int i = 0; i < 64; i++) begin
      pix_r[i] = 255; pix_g[i] = 0; pix_b[i] = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d, input logic last);
    int t = 0;
    s00_axis_tdata  = d;
    s00_axis_tlast  = last;
    s00_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s00_axis_tready) break;
      if (++t > 500) begin
        check("input_accept_timeout", 64'(s00_axis_tready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
  endtask

  task automatic send_block(input bit gaps);
    logic [31:0] d;
    out_cnt = 0;
    tlast_pos.delete();
    blk_first = 1;
    for (int ch = 0; ch < 3; ch++)
      for (int n = 0; n < 16; n++) begin
        if (gaps && $urandom_range(0, 2) == 0)
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        for (int k = 0; k < 4; k++) begin
          case (ch)
            0:       d[k*8 +: 8] = 8'(pix_r[4*n+k]);
            1:       d[k*8 +: 8] = 8'(pix_g[4*n+k]);
            default: d[k*8 +: 8] = 8'(pix_b[4*n+k]);
          endcase
        end
        send_beat(d, gaps ? 1'b0 : (n == 15));
      end
  endtask

  task automatic wait_outputs(input int n, input string name);
    int t = 0;
    while (out_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(out_cnt), 64'(n));
  endtask

  task automatic check_gradient_pins(input string tag);
    check({tag, "_y0"},   64'(got_buf[0]),   64'd10);
    check({tag, "_y7"},   64'(got_buf[7]),   64'd85);
    check({tag, "_y63"},  64'(got_buf[63]),  64'd220);
    check({tag, "_cb0"},  64'(got_buf[64]),  64'd128);
    check({tag, "_cb7"},  64'(got_buf[71]),  64'd145);
    check({tag, "_cb63"}, 64'(got_buf[127]), 64'd128);
    check({tag, "_cr0"},  64'(got_buf[128]), 64'd128);
    check({tag, "_cr7"},  64'(got_buf[135]), 64'd224);
    check({tag, "_cr63"}, 64'(got_buf[191]), 64'd128);
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin
    bit          prev_stall = 0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!s00_axis_aresetn) begin
        prev_stall = 0;
        continue;
      end
      if (s00_axis_tvalid && s00_axis_tready) last_in_cyc = cyc + 1;
      if (prev_stall) begin
        check("hold_valid", 64'(m00_axis_tvalid), 64'd1);
        check("hold_data", 64'(m00_axis_tdata), 64'(held_data));
        check("hold_last", 64'(m00_axis_tlast), 64'(held_last));
      end
      if (m00_axis_tvalid && blk_first) begin
        check("start_latency", 64'(cyc - last_in_cyc), 64'(START));
        blk_first = 0;
      end
      if (m00_axis_tvalid) check("in_ready_low_while_sending", 64'(s00_axis_tready), 64'd0);
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("output_without_expected", 64'(m00_axis_tvalid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sample", 64'(m00_axis_tdata), 64'(e[31:0]));
          check("tlast", 64'(m00_axis_tlast), 64'(e[32]));
          check("tstrb", 64'(m00_axis_tstrb), 64'hF);
          if (out_cnt < 192) got_buf[out_cnt] = int'(m00_axis_tdata);
          if (m00_axis_tlast) tlast_pos.push_back(out_cnt);
          out_cnt++;
        end
      end
      prev_stall = m00_axis_tvalid && !m00_axis_tready;
      held_data  = m00_axis_tdata;
      held_last  = m00_axis_tlast;
    end
  end

  // Output backpressure: toggles every cycle when enabled.
  initial begin
    m00_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m00_axis_tready = bp_mode ? ~m00_axis_tready : 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    s00_axis_aresetn = 1'b0;
    s00_axis_tdata   = '0;
    s00_axis_tstrb   = 4'hF;
    s00_axis_tlast   = 1'b0;
    s00_axis_tvalid  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tready", 64'(s00_axis_tready), 64'd0);
    check("rst_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("rst_tdata",  64'(m00_axis_tdata),  64'd0);
    check("rst_tlast",  64'(m00_axis_tlast),  64'd0);
    s00_axis_aresetn = 1'b1;
    #1 check("tready_before_first_edge", 64'(s00_axis_tready), 64'd0);
    @(negedge clk);
    check("tready_after_release", 64'(s00_axis_tready), 64'd1);
    repeat (40) @(negedge clk);
    check("idle_no_output", 64'(m00_axis_tvalid), 64'd0);
    @(posedge clk); #1;

    // Gradient block, free-flowing output
    set_gradient();
    build_expected();
    check("model_y7",  64'(exp_q[7][31:0]),   64'd85);
    check("model_cb7", 64'(exp_q[71][31:0]),  64'd145);
    check("model_cr7", 64'(exp_q[135][31:0]), 64'd224);
    check("model_last63", 64'(exp_q[63][32]), 64'd1);
    send_block(0);
    wait_outputs(192, "gradient_done");
    check_gradient_pins("grad");
    check("tlast_count", 64'(tlast_pos.size()), 64'd3);
    if (tlast_pos.size() == 3) begin
      check("tlast_pos0", 64'(tlast_pos[0]), 64'd63);
      check("tlast_pos1", 64'(tlast_pos[1]), 64'd127);
      check("tlast_pos2", 64'(tlast_pos[2]), 64'd191);
    end

    // Saturated red
    @(posedge clk); #1;
    set_saturate();
    build_expected();
    check("model_sat_cr", 64'(exp_q[128][31:0]), 64'd255);
    send_block(0);
    wait_outputs(192, "saturate_done");
    check("sat_y",  64'(got_buf[10]),  64'd76);
    check("sat_cb", 64'(got_buf[80]),  64'd85);
    check("sat_cr", 64'(got_buf[150]), 64'd255);

    // Toggling output backpressure
    @(posedge clk); #1;
    set_gradient();
    build_expected();
    bp_mode = 1;
    send_block(0);
    wait_outputs(192, "backpressure_done");
    bp_mode = 0;
    check_gradient_pins("bp");

    // Input gaps, tlast held low
    @(posedge clk); #1;
    build_expected();
    send_block(1);
    wait_outputs(192, "gaps_done");
    check_gradient_pins("gaps");

    // Reset while the Cb plane is streaming
    @(posedge clk); #1;
    build_expected();
    send_block(0);
    wait_outputs(70, "reach_cb");
    @(posedge clk); #1;
    s00_axis_aresetn = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("midrst_tdata",  64'(m00_axis_tdata),  64'd0);
    check("midrst_tlast",  64'(m00_axis_tlast),  64'd0);
    check("midrst_tready", 64'(s00_axis_tready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    s00_axis_aresetn = 1'b1;
    @(posedge clk); #1;
    set_saturate();
    build_expected();
    send_block(0);
    wait_outputs(192, "post_reset_done");
    check("post_reset_y", 64'(got_buf[0]), 64'd76);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "global timeout");
  end
endmodule
